// File: rtl/fft_mem_sequencer.sv
// RAM-side sequencer for an in-place radix-2 DIT FFT: walks every stage/butterfly, reads pairs, writes results back.
// Optional FFT_SEQ_CYCLE_CNT_EN adds a saturating busy-cycle counter on o_CYCLES.
module fft_mem_sequencer #(
    parameter int AWL    = 8,
    parameter int RD_LAT = 1
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                i_START,
    output logic                                o_BUSY,
    output logic                                o_DONE,
    output logic [4:0]                          o_STAGE,
    output logic                                o_EN_A,
    output logic                                o_WrE_A,
    output logic [AWL-1:0]                      o_ADDR_A,
    output logic                                o_EN_B,
    output logic                                o_WrE_B,
    output logic [AWL-1:0]                      o_ADDR_B,
    output logic [((AWL > 1) ? AWL-1 : 1)-1:0]  o_TW_ADDR,
    output logic                                o_BF_VALID,
    input  logic                                i_BF_VALID
`ifdef FFT_SEQ_CYCLE_CNT_EN
    ,output logic [31:0]                        o_CYCLES
`endif
);

    localparam int KW  = (AWL > 1) ? AWL-1 : 1;
    localparam int TWW = KW;
    localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [KW-1:0]  K_LAST = KW'((32'd1 << (AWL-1)) - 32'd1);
    localparam logic [4:0]     S_LAST = 5'(AWL-1);
    localparam logic [WCW-1:0] W_LAST = WCW'(RD_LAT-1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_BFW  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic [2:0]     state;
    logic [4:0]     stage;
    logic [KW-1:0]  k;
    logic [WCW-1:0] wait_cnt;

    logic           busy;
    logic           wr;
    logic [AWL-1:0] k_ext;
    logic [AWL-1:0] span;
    logic [AWL-1:0] pos;
    logic [AWL-1:0] grp;
    logic [AWL-1:0] addr_a;
    logic [AWL-1:0] addr_b;
    logic [4:0]     tw_shift;
    logic [TWW-1:0] tw_addr;

    // k advances only on a real write-back, so addresses stay put through read, wait and any butterfly stall.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            stage    <= '0;
            k        <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_START) state <= ST_RD;
                end
                ST_RD: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt == W_LAST) state <= ST_BFW;
                    else                    wait_cnt <= wait_cnt + 1'b1;
                end
                ST_BFW: begin
                    if (i_BF_VALID) begin
                        if (k == K_LAST) begin
                            k <= '0;
                            if (stage == S_LAST) begin
                                stage <= '0;
                                state <= ST_DONE;
                            end else begin
                                stage <= stage + 5'd1;
                                state <= ST_RD;
                            end
                        end else begin
                            k     <= k + 1'b1;
                            state <= ST_RD;
                        end
                    end
                end
                ST_DONE: begin
                    stage <= '0;
                    k     <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bit s of addr_a is always clear, so addr_b = addr_a + span never carries and never equals addr_a.
    always_comb begin
        k_ext    = AWL'(k);
        span     = AWL'(1) << stage;
        pos      = k_ext & (span - 1'b1);
        grp      = k_ext >> stage;
        addr_a   = (grp << (stage + 5'd1)) | pos;
        addr_b   = addr_a + span;
        tw_shift = S_LAST - stage;
        tw_addr  = (AWL > 1) ? TWW'(pos << tw_shift) : '0;
    end

    assign busy       = (state == ST_RD) || (state == ST_WAIT) || (state == ST_BFW);
    assign wr         = (state == ST_BFW) && i_BF_VALID;

    assign o_BUSY     = busy;
    assign o_DONE     = (state == ST_DONE);
    assign o_STAGE    = stage;
    assign o_EN_A     = (state == ST_RD) || wr;
    assign o_EN_B     = (state == ST_RD) || wr;
    assign o_WrE_A    = wr;
    assign o_WrE_B    = wr;
    assign o_ADDR_A   = busy ? addr_a : '0;
    assign o_ADDR_B   = busy ? addr_b : '0;
    assign o_TW_ADDR  = busy ? tw_addr : '0;
    assign o_BF_VALID = (state == ST_WAIT) && (wait_cnt == W_LAST);

`ifdef FFT_SEQ_CYCLE_CNT_EN
    logic [31:0] cycles;

    // Cleared as a run is launched, then frozen from DONE so the result can be read afterwards.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cycles <= '0;
        end else if ((state == ST_IDLE) && i_START) begin
            cycles <= '0;
        end else if (busy && (cycles != 32'hFFFF_FFFF)) begin
            cycles <= cycles + 32'd1;
        end
    end

    assign o_CYCLES = cycles;
`endif

endmodule

// File: tb/tb_fft_mem_sequencer.sv
// Directed bench for fft_mem_sequencer with AWL=3: one RD_LAT=1 instance and one RD_LAT=2 instance.
// Honours FFT_SEQ_CYCLE_CNT_EN to connect and check o_CYCLES.
module tb_fft_mem_sequencer;

    localparam int AWL = 3;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic rst;
    logic start;
    logic bfv;
    logic sel;
    int   rd_lat;

    int total = 0;
    int bad   = 0;
    int busy_cnt = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;

    logic [1:0] busy_o, done_o, en_a_o, en_b_o, wre_a_o, wre_b_o, bfv_o;
    logic [4:0] stage_o  [2];
    logic [2:0] addr_a_o [2];
    logic [2:0] addr_b_o [2];
    logic [1:0] tw_o     [2];
    logic [31:0] cyc_o   [2];

    int exp_a  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int exp_b  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int exp_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    fft_mem_sequencer #(.AWL(AWL), .RD_LAT(1)) u_dut_lat1 (
        .CLK(CLK), .RST(rst), .i_START(start && !sel),
        .o_BUSY(busy_o[0]), .o_DONE(done_o[0]), .o_STAGE(stage_o[0]),
        .o_EN_A(en_a_o[0]), .o_WrE_A(wre_a_o[0]), .o_ADDR_A(addr_a_o[0]),
        .o_EN_B(en_b_o[0]), .o_WrE_B(wre_b_o[0]), .o_ADDR_B(addr_b_o[0]),
        .o_TW_ADDR(tw_o[0]), .o_BF_VALID(bfv_o[0]), .i_BF_VALID(bfv && !sel)
`ifdef FFT_SEQ_CYCLE_CNT_EN
        ,.o_CYCLES(cyc_o[0])
`endif
    );

    fft_mem_sequencer #(.AWL(AWL), .RD_LAT(2)) u_dut_lat2 (
        .CLK(CLK), .RST(rst), .i_START(start && sel),
        .o_BUSY(busy_o[1]), .o_DONE(done_o[1]), .o_STAGE(stage_o[1]),
        .o_EN_A(en_a_o[1]), .o_WrE_A(wre_a_o[1]), .o_ADDR_A(addr_a_o[1]),
        .o_EN_B(en_b_o[1]), .o_WrE_B(wre_b_o[1]), .o_ADDR_B(addr_b_o[1]),
        .o_TW_ADDR(tw_o[1]), .o_BF_VALID(bfv_o[1]), .i_BF_VALID(bfv && sel)
`ifdef FFT_SEQ_CYCLE_CNT_EN
        ,.o_CYCLES(cyc_o[1])
`endif
    );

`ifndef FFT_SEQ_CYCLE_CNT_EN
    assign cyc_o[0] = '0;
    assign cyc_o[1] = '0;
`endif

    logic        m_busy, m_done, m_en_a, m_en_b, m_wre_a, m_wre_b, m_bfv;
    logic [4:0]  m_stage;
    logic [2:0]  m_addr_a, m_addr_b;
    logic [1:0]  m_tw;
    logic [31:0] m_cycles;

    assign m_busy   = busy_o[sel];
    assign m_done   = done_o[sel];
    assign m_en_a   = en_a_o[sel];
    assign m_en_b   = en_b_o[sel];
    assign m_wre_a  = wre_a_o[sel];
    assign m_wre_b  = wre_b_o[sel];
    assign m_bfv    = bfv_o[sel];
    assign m_stage  = stage_o[sel];
    assign m_addr_a = addr_a_o[sel];
    assign m_addr_b = addr_b_o[sel];
    assign m_tw     = tw_o[sel];
    assign m_cycles = cyc_o[sel];

    // Activity tallies for the selected instance, sampled well clear of both clock edges.
    always @(negedge CLK) begin
        #2;
        if (m_busy === 1'b1)  busy_cnt++;
        if (m_wre_a === 1'b1) wr_cnt++;
        if (m_done === 1'b1)  done_cnt++;
    end

    task automatic applyStimulus(input bit s, input bit v);
        start = s;
        bfv   = v;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One butterfly, entered just before its RD cycle; lbf counts cycles from o_BF_VALID to i_BF_VALID.
    task automatic do_bf(input int b, input int lbf, input bit noisy);
        logic [31:0] ea, eb;
        ea = 32'(exp_a[b]);
        eb = 32'(exp_b[b]);
        @(negedge CLK);
        applyStimulus(0, 0);
        #1;
        checkOutput($sformatf("bf%0d rd ctl", b), {m_en_a, m_en_b, m_wre_a, m_wre_b, m_bfv, m_busy}, 6'b110001);
        checkOutput($sformatf("bf%0d rd addr_a", b), m_addr_a, ea);
        checkOutput($sformatf("bf%0d rd addr_b", b), m_addr_b, eb);
        for (int w = 1; w <= rd_lat; w++) begin
            @(negedge CLK);
            if (noisy && (w == rd_lat)) applyStimulus(1, 1);
            else                        applyStimulus(0, 0);
            #1;
            checkOutput($sformatf("bf%0d wait%0d ctl", b, w), {m_en_a, m_en_b, m_wre_a, m_wre_b, m_busy}, 5'b00001);
            checkOutput($sformatf("bf%0d wait%0d bf_valid", b, w), m_bfv, (w == rd_lat));
            if (w == rd_lat) begin
                checkOutput($sformatf("bf%0d tw", b), m_tw, 32'(exp_tw[b]));
                checkOutput($sformatf("bf%0d stage", b), m_stage, 32'(b / 4));
                checkOutput($sformatf("bf%0d wait addr", b), {m_addr_a, m_addr_b}, {ea[2:0], eb[2:0]});
            end
        end
        for (int c = 1; c <= lbf; c++) begin
            @(negedge CLK);
            applyStimulus(0, (c == lbf));
            #1;
            checkOutput($sformatf("bf%0d bfw%0d en/we", b, c), {m_en_a, m_en_b, m_wre_a, m_wre_b},
                        (c == lbf) ? 4'b1111 : 4'b0000);
            checkOutput($sformatf("bf%0d bfw%0d addr", b, c), {m_addr_a, m_addr_b}, {ea[2:0], eb[2:0]});
            checkOutput($sformatf("bf%0d bfw%0d busy/bfv", b, c), {m_busy, m_bfv}, 2'b10);
        end
    endtask

    task automatic run_fft(input bit which, input int stall_idx, input bit noisy, input int exp_busy);
        sel    = which;
        rd_lat = which ? 2 : 1;
        @(negedge CLK);
        busy_cnt = 0;
        wr_cnt   = 0;
        done_cnt = 0;
        applyStimulus(1, 0);
        #1;
        checkOutput("start idle busy", m_busy, 0);
        for (int b = 0; b < 12; b++) do_bf(b, (b == stall_idx) ? 12 : 2, noisy);
        @(negedge CLK);
        applyStimulus(0, 0);
        #1;
        checkOutput("done pulse", {m_done, m_busy, m_en_a, m_wre_a}, 4'b1000);
`ifdef FFT_SEQ_CYCLE_CNT_EN
        checkOutput("cycle count", m_cycles, 32'(exp_busy));
`endif
        @(negedge CLK);
        #1;
        checkOutput("after done", {m_done, m_busy}, 2'b00);
        #2;
        checkOutput("busy cycles", busy_cnt, 32'(exp_busy));
        checkOutput("write cycles", wr_cnt, 32'd12);
        checkOutput("done pulses", done_cnt, 32'd1);
    endtask

    initial begin
        $display("[TB] start");
        rst    = 1'b1;
        sel    = 1'b0;
        rd_lat = 1;
        applyStimulus(0, 0);
        repeat (2) @(negedge CLK);
        #1;
        checkOutput("reset ctl", {m_busy, m_done, m_en_a, m_en_b, m_wre_a, m_wre_b, m_bfv}, 7'b0);
        checkOutput("reset addr", {m_addr_a, m_addr_b, m_tw}, 8'b0);
        checkOutput("reset stage", m_stage, 0);
        @(negedge CLK);
        rst = 1'b0;

        $display("[TB] plain run, RD_LAT=1");
        run_fft(0, -1, 0, 48);

        $display("[TB] stall on butterfly 5 with spurious start/valid");
        run_fft(0, 5, 1, 58);

        $display("[TB] plain run, RD_LAT=2");
        run_fft(1, -1, 0, 60);

        $display("[TB] reset during stage 1 write-back wait");
        sel    = 1'b0;
        rd_lat = 1;
        @(negedge CLK);
        applyStimulus(1, 0);
        for (int b = 0; b < 5; b++) do_bf(b, 2, 0);
        @(negedge CLK);
        applyStimulus(0, 0);
        @(negedge CLK);
        @(negedge CLK);
        #1;
        checkOutput("pre-reset stage/busy", {m_stage, m_busy}, {5'd1, 1'b1});
        rst = 1'b1;
        #1;
        checkOutput("async reset ctl", {m_busy, m_done, m_en_a, m_en_b, m_wre_a, m_wre_b, m_bfv}, 7'b0);
        checkOutput("async reset addr", {m_addr_a, m_addr_b, m_tw}, 8'b0);
        checkOutput("async reset stage", m_stage, 0);
        @(negedge CLK);
        rst = 1'b0;
        run_fft(0, -1, 0, 48);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
